// File: rtl/uart_cmd_apb_ctrl.sv
// Bridges parsed UART commands to a single APB master transfer and streams
// the ASCII response ("K", "E" or 8 uppercase hex digits, then CR) to the TX.
module uart_cmd_apb_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        iCLK,
    input  logic        iRESET,
    input  logic        iCMD_VALID,
    output logic        oCMD_READY,
    input  logic        iCMD_WR,
    input  logic        iCMD_ERR,
    input  logic [31:0] iCMD_ADDR,
    input  logic [31:0] iCMD_WDATA,
    output logic        oPSEL,
    output logic        oPENABLE,
    output logic        oPWRITE,
    output logic [31:0] oPADDR,
    output logic [31:0] oPWDATA,
    input  logic [31:0] iPRDATA,
    input  logic        iPREADY,
    input  logic        iPSLVERR,
    output logic [7:0]  oTX_DATA,
    output logic        oTX_VALID,
    input  logic        iTX_READY,
    output logic        oBUSY
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, SEND} state_e;
    typedef enum logic [1:0] {RSP_ERR, RSP_OK, RSP_HEX} rsp_e;

    state_e            r_state;
    rsp_e              r_kind;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;
    logic [31:0]       r_rdata;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [3:0]        r_idx;
    logic [CNT_W-1:0]  r_cnt;

    rsp_e              w_cmpl_kind;
    logic [3:0]        w_last_idx;
    logic [7:0]        w_next_byte;

    // Byte idx of a response: letter+CR, or 8 hex digits (MSB first) + CR.
    function automatic logic [7:0] rsp_byte(input rsp_e kind, input logic [31:0] data,
                                            input logic [3:0] idx);
        logic [31:0] sh;
        logic [3:0]  nib;
        logic [7:0]  b;
        sh  = data << {idx[2:0], 2'b00};
        nib = sh[31:28];
        b   = CH_CR;
        case (kind)
            RSP_ERR: if (idx == 4'd0) b = CH_E;
            RSP_OK:  if (idx == 4'd0) b = CH_K;
            default: if (idx < 4'd8)
                         b = (nib < 4'd10) ? 8'h30 + 8'(nib) : 8'h37 + 8'(nib);
        endcase
        return b;
    endfunction

    always_comb begin
        w_cmpl_kind = RSP_HEX;
        if (iPSLVERR)      w_cmpl_kind = RSP_ERR;
        else if (r_pwrite) w_cmpl_kind = RSP_OK;
        w_last_idx  = (r_kind == RSP_HEX) ? 4'd8 : 4'd1;
        w_next_byte = rsp_byte(r_kind, r_rdata, 4'(r_idx + 4'd1));
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state     <= IDLE;
            r_kind      <= RSP_ERR;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rdata     <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_idx       <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (iCMD_VALID && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pwrite    <= iCMD_WR;
                        r_paddr     <= iCMD_ADDR;
                        r_pwdata    <= iCMD_WDATA;
                        r_idx       <= '0;
                        if (iCMD_ERR) begin
                            r_kind     <= RSP_ERR;
                            r_tx_data  <= CH_E;
                            r_tx_valid <= 1'b1;
                            r_state    <= SEND;
                        end else begin
                            r_psel  <= 1'b1;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    // iPREADY wins over a coincident timeout terminal count.
                    if (iPREADY) begin
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_rdata    <= iPRDATA;
                        r_kind     <= w_cmpl_kind;
                        r_tx_data  <= rsp_byte(w_cmpl_kind, iPRDATA, 4'd0);
                        r_tx_valid <= 1'b1;
                        r_idx      <= '0;
                        r_state    <= SEND;
                    end else if (r_cnt == CNT_LAST) begin
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_kind     <= RSP_ERR;
                        r_tx_data  <= CH_E;
                        r_tx_valid <= 1'b1;
                        r_idx      <= '0;
                        r_state    <= SEND;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                SEND: begin
                    if (iTX_READY) begin
                        if (r_idx == w_last_idx) begin
                            r_tx_valid  <= 1'b0;
                            r_idx       <= '0;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_idx     <= 4'(r_idx + 4'd1);
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oCMD_READY = r_cmd_ready;
    assign oBUSY      = r_busy;
    assign oPSEL      = r_psel;
    assign oPENABLE   = r_penable;
    assign oPWRITE    = r_pwrite;
    assign oPADDR     = r_paddr;
    assign oPWDATA    = r_pwdata;
    assign oTX_DATA   = r_tx_data;
    assign oTX_VALID  = r_tx_valid;

endmodule

// File: doc/uart_cmd_apb_ctrl.md
UART_CMD_APB_CTRL -- requirements
Module: uart_cmd_apb_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, the maximum number of ACCESS cycles to wait for iPREADY before aborting.
REQ-002 SHALL have port: iCLK  in  1  the single clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port: iRESET  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port: iCMD_VALID  in  1  a parsed UART command is available.
REQ-005 SHALL have port: oCMD_READY  out  1  the controller can accept a command.
REQ-006 SHALL have port: iCMD_WR  in  1  command type: 1=write ("w"), 0=read ("r").
REQ-007 SHALL have port: iCMD_ERR  in  1  the parser detected a syntax error.
REQ-008 SHALL have port: iCMD_ADDR  in  32  APB address.
REQ-009 SHALL have port: iCMD_WDATA  in  32  write data.
REQ-010 SHALL have APB master ports: oPSEL, oPENABLE, oPWRITE (out 1 each); oPADDR, oPWDATA (out 32 each); iPRDATA (in 32); iPREADY, iPSLVERR (in 1 each).
REQ-011 SHALL have port: oTX_DATA  out  8  the response byte sent to the UART TX.
REQ-012 SHALL have port: oTX_VALID  out  1  oTX_DATA is valid.
REQ-013 SHALL have port: iTX_READY  in  1  the TX accepts the byte in this cycle.
REQ-014 SHALL have port: oBUSY  out  1  high in every state except IDLE.

Function
REQ-015 SHALL implement exactly these states: IDLE, SETUP, ACCESS, SEND.
REQ-016 SHALL drive oCMD_READY=1 only in IDLE; a command is accepted when iCMD_VALID and oCMD_READY are both high, and iCMD_WR, iCMD_ADDR and iCMD_WDATA are registered on that edge.
REQ-017 IDLE, on an accepted command with iCMD_ERR=1: SHALL go to SEND with the response "E",CR (0x45,0x0D) and SHALL NOT start any APB cycle.
REQ-018 IDLE, on an accepted command with iCMD_ERR=0: SHALL go to SETUP; oPSEL=1 and oPENABLE=0 one cycle after acceptance.
REQ-019 SETUP SHALL last exactly one cycle and then go to ACCESS with oPSEL=1 and oPENABLE=1.
REQ-020 oPADDR, oPWRITE and oPWDATA SHALL hold their registered values and stay stable from SETUP through the final ACCESS cycle.
REQ-021 ACCESS, on iPREADY=1: SHALL complete the transfer; on the next edge oPSEL=0, oPENABLE=0, and the state goes to SEND.
REQ-022 Completion response SHALL be chosen as follows:
- iPSLVERR=1: "E",CR.
- write with iPSLVERR=0: "K",CR (0x4B,0x0D).
- read with iPSLVERR=0: iPRDATA is captured in the iPREADY cycle and the response is 8 hex characters, MSB nibble first, followed by CR (9 bytes).
REQ-023 Hex encoding SHALL use uppercase: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x37+n.
REQ-024 ACCESS timeout: SHALL count ACCESS cycles with iPREADY=0; once the count reaches TIMEOUT, the next edge drops oPSEL and oPENABLE and goes to SEND with "E",CR.
REQ-025 SEND SHALL hold oTX_VALID=1 with a stable oTX_DATA until iTX_READY=1; each accepted byte advances the byte index on that edge.
REQ-026 After the final CR byte is accepted, SHALL return to IDLE on that edge; oTX_VALID=0 in IDLE.
REQ-027 iCMD_VALID SHALL be ignored in SETUP, ACCESS and SEND; no command is queued.
REQ-028 The internal byte index SHALL be 4 bits; the response length is 2 or 9, and the index never wraps.
REQ-029 If iPREADY and the timeout terminal count occur in the same cycle, iPREADY SHALL take priority and the normal response is sent.

Reset
REQ-030 iRESET=1 at a rising edge SHALL set:
- state to IDLE;
- oPSEL, oPENABLE, oPWRITE, oTX_VALID and oBUSY to 0;
- oPADDR, oPWDATA, oTX_DATA, the counters and the captured data to 0.
REQ-031 oCMD_READY SHALL be 0 while iRESET is high and 1 in the first cycle after reset deassertion.
REQ-032 Reset during SETUP, ACCESS or SEND SHALL abort immediately (APB drops within the same edge, the pending response is discarded), with no partial completion afterwards.

Verification
REQ-033 Write test: iCMD_WR=1, addr 0x10, data 0xDEADBEEF, iPREADY=1 in the first ACCESS cycle -> PSEL at accept+1, PENABLE at accept+2, PWDATA=0xDEADBEEF; TX emits 0x4B,0x0D.
REQ-034 Read test: addr 0x20, iPRDATA=0x00A5F00C with iPREADY after 3 wait cycles -> TX emits "00A5F00C",CR (0x30,0x30,0x41,0x35,0x46,0x30,0x30,0x43,0x0D).
REQ-035 Error paths:
- iCMD_ERR=1 -> no PSEL pulse; TX emits 0x45,0x0D.
- iPSLVERR=1 on a write -> TX emits 0x45,0x0D.
REQ-036 Timeout test: TIMEOUT=4, iPREADY held at 0 -> PSEL and PENABLE drop after 4 ACCESS cycles; TX emits "E",CR; oCMD_READY=1 afterwards.
REQ-037 Backpressure and reset test: iTX_READY toggles 1-0-1 during a read response -> no byte is lost or duplicated and oTX_DATA stays stable while stalled; asserting iRESET mid-SEND -> all outputs are 0 on the next edge.
